nes_joypad_responder: RTL and testbench

NES_JOYPAD_RESPONDER -- requirements
Module: nes_joypad_responder

---
 rtl/nes_joypad_responder.sv | 113 +++++++++++
 tb/tb_nes_joypad_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/nes_joypad_responder.sv
// NES controller responder: synchronizes the console latch/clock lines and shifts out an
// active-low button report. Define JOYPAD_TURBO_EN to enable A/B autofire.
module nes_joypad_responder (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] buttons,
    input  logic       turbo_a,
    input  logic       turbo_b,
    input  logic       joy_strobe,
    input  logic       joy_clock,
    output logic       joy_data,
    output logic [3:0] shift_count,
    output logic       polled
);

    logic [1:0] strobe_sync_reg;
    logic [1:0] clk_sync_reg;
    logic       strobe_dly_reg;
    logic       clk_dly_reg;
    logic [7:0] btn_meta_reg;
    logic [7:0] btn_sync_reg;
    logic [7:0] sr_reg;
    logic [3:0] count_reg;
    logic [7:0] eff;
    logic       strobe_now;
    logic       strobe_fall;
    logic       clk_rise;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            strobe_sync_reg <= 2'b00;
            clk_sync_reg    <= 2'b00;
            strobe_dly_reg  <= 1'b0;
            clk_dly_reg     <= 1'b0;
            btn_meta_reg    <= 8'h00;
            btn_sync_reg    <= 8'h00;
        end else begin
            strobe_sync_reg <= {strobe_sync_reg[0], joy_strobe};
            clk_sync_reg    <= {clk_sync_reg[0], joy_clock};
            strobe_dly_reg  <= strobe_sync_reg[1];
            clk_dly_reg     <= clk_sync_reg[1];
            btn_meta_reg    <= buttons;
            btn_sync_reg    <= btn_meta_reg;
        end
    end

    assign strobe_now  = strobe_sync_reg[1];
    assign strobe_fall = strobe_dly_reg & ~strobe_sync_reg[1];
    assign clk_rise    = clk_sync_reg[1] & ~clk_dly_reg;
    assign polled      = strobe_fall;

`ifdef JOYPAD_TURBO_EN
    logic [1:0] turbo_meta_reg;
    logic [1:0] turbo_sync_reg;
    logic [1:0] phase_reg;

    // Phase advances once per poll: phases 0,1 report turbo as pressed, 2,3 as released.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            turbo_meta_reg <= 2'b00;
            turbo_sync_reg <= 2'b00;
            phase_reg      <= 2'd0;
        end else begin
            turbo_meta_reg <= {turbo_b, turbo_a};
            turbo_sync_reg <= turbo_meta_reg;
            if (strobe_fall) begin
                phase_reg <= phase_reg + 2'd1;
            end
        end
    end
`else
    logic unused_turbo;
    assign unused_turbo = turbo_a ^ turbo_b;
`endif

    always_comb begin
        eff = btn_sync_reg;
        // Opposing directions cancel so games never see an impossible D-pad state.
        if (btn_sync_reg[7] & btn_sync_reg[6]) begin
            eff[7:6] = 2'b00;
        end
        if (btn_sync_reg[5] & btn_sync_reg[4]) begin
            eff[5:4] = 2'b00;
        end
`ifdef JOYPAD_TURBO_EN
        eff[0] = btn_sync_reg[0] | (turbo_sync_reg[0] & ~phase_reg[1]);
        eff[1] = btn_sync_reg[1] | (turbo_sync_reg[1] & ~phase_reg[1]);
`endif
    end

    // The falling-edge cycle reloads once more, so the frozen report matches that cycle's eff.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sr_reg    <= 8'hFF;
            count_reg <= 4'd0;
            joy_data  <= 1'b1;
        end else begin
            if (strobe_now || strobe_fall) begin
                sr_reg    <= ~eff;
                count_reg <= 4'd0;
            end else if (clk_rise) begin
                sr_reg <= {1'b0, sr_reg[7:1]};
                if (count_reg != 4'd8) begin
                    count_reg <= count_reg + 4'd1;
                end
            end
            joy_data <= sr_reg[0];
        end
    end

    assign shift_count = count_reg;

endmodule

// File: tb/tb_nes_joypad_responder.sv
// Self-checking bench for nes_joypad_responder: directed frames plus randomized frames
// compared against a report-level model of the button protocol.
module tb_nes_joypad_responder;

    logic       clock;
    logic       reset_n;
    logic [7:0] buttons;
    logic       turbo_a;
    logic       turbo_b;
    logic       joy_strobe;
    logic       joy_clock;
    logic       joy_data;
    logic [3:0] shift_count;
    logic       polled;

    int tests;
    int failed;
    int poll_cnt;
    int polls;

    nes_joypad_responder dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .buttons     (buttons),
        .turbo_a     (turbo_a),
        .turbo_b     (turbo_b),
        .joy_strobe  (joy_strobe),
        .joy_clock   (joy_clock),
        .joy_data    (joy_data),
        .shift_count (shift_count),
        .polled      (polled)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (polled === 1'b1) poll_cnt++;
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Effective pressed set for one poll; poll_idx is the number of polls since reset.
    function automatic logic [7:0] eff_model(input logic [7:0] b, input bit ta, input bit tb_,
                                             input int poll_idx);
        logic [7:0] e;
        e = b;
        if (b[7] && b[6]) begin e[7] = 1'b0; e[6] = 1'b0; end
        if (b[5] && b[4]) begin e[5] = 1'b0; e[4] = 1'b0; end
`ifdef JOYPAD_TURBO_EN
        if ((poll_idx % 4) < 2) begin
            if (ta)  e[0] = 1'b1;
            if (tb_) e[1] = 1'b1;
        end
`else
        if (ta || tb_ || poll_idx < 0) e = e;
`endif
        return e;
    endfunction

    task automatic pulse_clock;
        joy_clock = 1'b1;
        wait_cycles(3);
        joy_clock = 1'b0;
        wait_cycles(4);
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        joy_strobe = 1'b0;
        joy_clock = 1'b0;
        wait_cycles(3);
        reset_n = 1'b1;
        polls = 0;
        wait_cycles(3);
    endtask

    // Latch a report, then read bit 0 and one further bit after each of nclk shifts.
    task automatic run_frame(input string tag, input logic [7:0] b, input bit ta, input bit tb_,
                             input int nclk, input bit scramble);
        logic [7:0] e;
        int p0;
        buttons = b;
        turbo_a = ta;
        turbo_b = tb_;
        e = eff_model(b, ta, tb_, polls);
        p0 = poll_cnt;
        joy_strobe = 1'b1;
        wait_cycles(5);
        joy_strobe = 1'b0;
        wait_cycles(6);
        polls++;
        check({tag, "_polled"}, 8'(poll_cnt - p0), 8'd1);
        for (int k = 0; k <= nclk; k++) begin
            if (scramble) buttons = 8'($urandom);
            check($sformatf("%s_bit%0d", tag, k), {7'd0, joy_data},
                  {7'd0, (k < 8) ? ~e[k] : 1'b0});
            check($sformatf("%s_cnt%0d", tag, k), {4'd0, shift_count},
                  8'((k < 8) ? k : 8));
            if (k < nclk) pulse_clock();
        end
        $display("[TB] frame %s buttons=%02h turbo=%0d%0d clocks=%0d", tag, b, ta, tb_, nclk);
    endtask

    initial begin
        tests = 0;
        failed = 0;
        poll_cnt = 0;
        polls = 0;
        buttons = 8'h00;
        turbo_a = 1'b0;
        turbo_b = 1'b0;
        joy_strobe = 1'b0;
        joy_clock = 1'b0;
        reset_n = 1'b0;
        wait_cycles(3);
        check("rst_data", {7'd0, joy_data}, 8'd1);
        check("rst_cnt", {4'd0, shift_count}, 8'd0);
        check("rst_polled", {7'd0, polled}, 8'd0);
        reset_n = 1'b1;
        wait_cycles(3);
        $display("[TB] reset checked");

        run_frame("start_a", 8'h09, 1'b0, 1'b0, 8, 1'b0);
        run_frame("all_conf", 8'hFF, 1'b0, 1'b0, 10, 1'b0);
        run_frame("left_right", 8'hC0, 1'b0, 1'b0, 8, 1'b0);
        run_frame("up_down", 8'h30, 1'b0, 1'b0, 8, 1'b1);

        // Shift clock while the latch is open must not shift.
        buttons = 8'h01;
        joy_strobe = 1'b1;
        wait_cycles(5);
        check("hold_data0", {7'd0, joy_data}, 8'd0);
        joy_clock = 1'b1;
        wait_cycles(6);
        check("hold_data1", {7'd0, joy_data}, 8'd0);
        check("hold_cnt", {4'd0, shift_count}, 8'd0);
        joy_clock = 1'b0;
        wait_cycles(3);
        joy_strobe = 1'b0;
        wait_cycles(6);
        polls++;
        check("hold_data2", {7'd0, joy_data}, 8'd0);
        check("hold_cnt2", {4'd0, shift_count}, 8'd0);
        $display("[TB] clock-during-strobe checked");

        // Reset in the middle of a report.
        buttons = 8'h00;
        joy_strobe = 1'b1;
        wait_cycles(5);
        joy_strobe = 1'b0;
        wait_cycles(6);
        polls++;
        for (int i = 0; i < 3; i++) pulse_clock();
        check("mid_cnt3", {4'd0, shift_count}, 8'd3);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_data", {7'd0, joy_data}, 8'd1);
        check("mid_rst_cnt", {4'd0, shift_count}, 8'd0);
        wait_cycles(2);
        reset_n = 1'b1;
        polls = 0;
        wait_cycles(3);
        $display("[TB] mid-frame reset checked");
        run_frame("after_rst", 8'h02, 1'b0, 1'b0, 2, 1'b0);

        // Autofire sequence from a fresh reset.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            int p0;
            logic exp_bit;
            buttons = 8'h00;
            turbo_a = 1'b1;
            turbo_b = 1'b0;
`ifdef JOYPAD_TURBO_EN
            exp_bit = ((i % 4) < 2) ? 1'b0 : 1'b1;
`else
            exp_bit = 1'b1;
`endif
            p0 = poll_cnt;
            joy_strobe = 1'b1;
            wait_cycles(5);
            joy_strobe = 1'b0;
            wait_cycles(6);
            polls++;
            check($sformatf("turbo_poll%0d", i), 8'(poll_cnt - p0), 8'd1);
            check($sformatf("turbo_bit0_%0d", i), {7'd0, joy_data}, {7'd0, exp_bit});
            $display("[TB] turbo poll %0d bit0=%0b", i, joy_data);
        end

        // Randomized frames.
        do_reset();
        for (int f = 0; f < 20; f++) begin
            run_frame($sformatf("rnd%0d", f), 8'($urandom), 1'($urandom), 1'($urandom),
                      int'($urandom_range(8, 10)), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
